codec_adc_rx: RTL
=================

// Module: codec_adc_rx
// PURPOSE
//  Audio codec ADC front end that feeds the voice-change datapath.
//  Generates the I2S bit clock (bclk) and word clock (lrck) from the system clock.
//  Deserialises one channel of ADC serial data into 16-bit two's-complement samples.
//  Presents each sample with a one-cycle ready strobe, which drives the voice block's SampleIn/ready.
// PARAMETERS
//  BCLK_DIV    4   clk cycles per bclk half-period; must be >= 2
//  SLOT_BITS   32  bclk periods per channel slot; power of two, >= SAMPLE_BITS+1
//  SAMPLE_BITS 16  captured bits per sample
//  CHANNEL     0   captured slot: 0 = left (lrck=0), 1 = right (lrck=1)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  enable     in   1   1 = run the interface; 0 = idle and clear frame position
//  adc_dat    in   1   codec serial data; codec changes it on bclk falling edge
//  bclk       out  1   bit clock to codec, registered
//  lrck       out  1   word clock to codec: 0 = left slot, 1 = right slot
//  SampleIn   out  16  last complete sample, MSB first on the wire; held between strobes
//  ready      out  1   1-cycle strobe: SampleIn updated this cycle
// BEHAVIOUR
//  Reset state: all registers 0, so bclk=0, lrck=0, SampleIn=0, ready=0.
//  Divider: div_cnt counts 0..BCLK_DIV-1 while enable=1; bclk toggles at wrap.
//   - rise_ev = wrap & bclk==0
//   - fall_ev = wrap & bclk==1
//  Frame counter: bit_cnt counts 0..2*SLOT_BITS-1 and wraps to 0.
//   - Advances on fall_ev only.
//   - lrck = bit_cnt MSB, driven from a register with no combinational path.
//   - slot_idx = bit_cnt mod SLOT_BITS.
//  Capture (I2S format, MSB one bclk after the lrck edge):
//   - On rise_ev, if the slot equals CHANNEL and 1 <= slot_idx <= SAMPLE_BITS, shift adc_dat in at the LSB.
//   - Bits with slot_idx 0 or > SAMPLE_BITS are ignored.
//   - adc_dat is sampled directly with no synchronizer; a bclk half-period >= 2 clk gives the setup margin.
//  Output: on the rise_ev that captures slot_idx==SAMPLE_BITS:
//   - SampleIn <= {shift[SAMPLE_BITS-2:0], adc_dat} and ready <= 1.
//   - The next cycle ready <= 0.
//   - Exactly one strobe per frame.
//  Latency: call the first clk edge that sees enable=1 edge 1. The first rise_ev falls on edge BCLK_DIV.
//   - Bit k is captured on edge (2k+1)*BCLK_DIV of its slot.
//   - CHANNEL 0: ready is high in the cycle after edge (2*SAMPLE_BITS+1)*BCLK_DIV (edge 132 with defaults).
//   - CHANNEL 1: add 2*SLOT_BITS*BCLK_DIV edges.
//   - Steady-state strobe period is 4*SLOT_BITS*BCLK_DIV clk (512 with defaults).
//  enable=0, including mid-frame:
//   - The next edge clears div_cnt, bclk, bit_cnt and the shift register; lrck is 0 while idle.
//   - The partial sample is discarded and no strobe is issued.
//   - SampleIn keeps its last value.
//   - Re-enable starts a fresh frame at bit_cnt=0.
//  reset mid-frame: immediate return to the reset state; no strobe is issued.
//  A rise_ev and a fall_ev never coincide; the bit_cnt wrap coincides with a fall_ev only.
//  Arithmetic: no sign processing; bits are passed as received. Counter widths are $clog2 of their ranges.
// STRUCTURE
//  Shared package: SAMPLE_BITS=16, CH_LEFT=0, CH_RIGHT=1, and the default BCLK_DIV and SLOT_BITS.
//  Sub-module codec_clk_gen: divider, bclk, bit_cnt and lrck.
//   - Outputs rise_ev, fall_ev and slot_idx; it is reused by the future DAC transmitter.
//  Top level holds the capture shift register, the SampleIn register and ready.
// TESTING
//  1 Defaults, codec model sends 16'hA5C3 in the left slot and 16'h1234 in the right:
//    ready is high exactly 1 cycle, after edge 132, with SampleIn=16'hA5C3; period 512 clk.
//  2 CHANNEL=1 with the same stimulus: SampleIn=16'h1234, first ready after edge 388.
//  3 Slot bits 0 and 17..31 driven to 1, payload 16'h0000: SampleIn=16'h0000, proving the bit window.
//  4 enable dropped at bit_cnt=10 and raised 50 clk later:
//    no strobe, bclk/lrck low while idle, next ready after edge 132 counted from re-enable.
//  5 reset asserted mid-slot, asynchronously between clk edges:
//    outputs are 0 immediately with no strobe; the first ready after release comes at edge 132.
//  6 BCLK_DIV=2, 8 frames of random data: every SampleIn matches the model; 8 strobes, 256 clk apart.

Source files
------------

// File: rtl/codec_adc_rx_pkg.sv
// Shared constants for the codec serial front end (ADC receiver, future DAC transmitter).
package codec_adc_rx_pkg;

    localparam int unsigned SAMPLE_BITS   = 16;
    localparam int unsigned CH_LEFT       = 0;
    localparam int unsigned CH_RIGHT      = 1;
    localparam int unsigned DEF_BCLK_DIV  = 4;
    localparam int unsigned DEF_SLOT_BITS = 32;

endpackage

// File: rtl/codec_clk_gen.sv
// I2S clock generator: bclk divider, frame bit counter and lrck.
// Exposes bclk edge events and the bit position within the current slot.
module codec_clk_gen
    import codec_adc_rx_pkg::*;
#(
    parameter int unsigned BCLK_DIV  = DEF_BCLK_DIV,
    parameter int unsigned SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         bclk,
    output logic                         lrck,
    output logic                         riseEv,
    output logic                         fallEv,
    output logic [$clog2(SLOT_BITS)-1:0] slotIdx
);

    localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BW = $clog2(2 * SLOT_BITS);
    localparam int unsigned SW = $clog2(SLOT_BITS);

    logic [DW-1:0] divCnt;
    logic [BW-1:0] bitCnt;
    logic          wrap;

    assign wrap    = enable && (divCnt == DW'(BCLK_DIV - 1));
    assign riseEv  = wrap && !bclk;
    assign fallEv  = wrap && bclk;
    // lrck is the counter MSB flop itself, so the codec sees no combinational glitching.
    assign lrck    = bitCnt[BW-1];
    assign slotIdx = bitCnt[SW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
            bitCnt <= '0;
            bclk   <= 1'b0;
        end else if (!enable) begin
            divCnt <= '0;
            bitCnt <= '0;
            bclk   <= 1'b0;
        end else begin
            if (wrap) begin
                divCnt <= '0;
                bclk   <= ~bclk;
            end else begin
                divCnt <= divCnt + DW'(1);
            end
            if (fallEv) begin
                bitCnt <= bitCnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/codec_adc_rx.sv
// Codec ADC receiver: deserialises one I2S channel into SampleIn with a one-cycle ready strobe.
module codec_adc_rx
    import codec_adc_rx_pkg::*;
#(
    parameter int unsigned BCLK_DIV  = DEF_BCLK_DIV,
    parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
    parameter int unsigned CHANNEL   = CH_LEFT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   adc_dat,
    output logic                   bclk,
    output logic                   lrck,
    output logic [SAMPLE_BITS-1:0] SampleIn,
    output logic                   ready
);

    localparam int unsigned SW = $clog2(SLOT_BITS);

    logic                   riseEv;
    logic                   fallEv;
    logic [SW-1:0]          slotIdx;
    logic [SAMPLE_BITS-1:0] shiftReg;
    logic                   capture;
    logic                   lastBit;

    codec_clk_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clkGen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bclk    (bclk),
        .lrck    (lrck),
        .riseEv  (riseEv),
        .fallEv  (fallEv),
        .slotIdx (slotIdx)
    );

    // Slot index 0 is the I2S one-bit delay after the lrck edge; payload occupies 1..SAMPLE_BITS.
    assign capture = riseEv && (lrck == 1'(CHANNEL))
                     && (slotIdx != '0) && (slotIdx <= SW'(SAMPLE_BITS));
    assign lastBit = slotIdx == SW'(SAMPLE_BITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg <= '0;
            SampleIn <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (!enable) begin
                shiftReg <= '0;
            end else if (capture) begin
                shiftReg <= {shiftReg[SAMPLE_BITS-2:0], adc_dat};
                if (lastBit) begin
                    SampleIn <= {shiftReg[SAMPLE_BITS-2:0], adc_dat};
                    ready    <= 1'b1;
                end
            end
        end
    end

    evNoOverlap : assert property (@(posedge clk) disable iff (reset) !(riseEv && fallEv));

endmodule
